// File: rtl/w4823_cmem_loader_pkg.sv
// Constants shared by the W4823 FIR and its coefficient-memory loader:
// CMEM geometry, coefficient width and the loader FSM encodings.
package w4823_cmem_loader_pkg;

  localparam int NTAPS          = 64;
  localparam int AW             = 6;
  localparam int CW             = 17;
  localparam int BYTES_PER_COEF = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_B0   = 3'd1;
  localparam logic [2:0] ST_B1   = 3'd2;
  localparam logic [2:0] ST_B2   = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;
  localparam logic [2:0] ST_CHK  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

endpackage

// File: rtl/w4823_cmem_loader.sv
// Assembles 17-bit coefficients from a big-endian byte stream, writes them
// to the FIR CMEM at addresses 0..NTAPS-1 and verifies a trailing checksum.
module w4823_cmem_loader
  import w4823_cmem_loader_pkg::*;
(
  input  logic          clk_fast,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic [CW-1:0] cin,
  output logic [AW-1:0] caddr,
  output logic          cload,
  output logic          busy,
  output logic          done,
  output logic          err
);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic          b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic          err_q, err_d;
  logic [CW-1:0] cin_q, cin_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic          xfer;

  assign byte_ready = (state_q == ST_B0) || (state_q == ST_B1) ||
                      (state_q == ST_B2) || (state_q == ST_CHK);
  assign xfer       = byte_valid && byte_ready;
  assign cload      = (state_q == ST_WR);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign cin        = cin_q;
  assign caddr      = caddr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    err_d   = err_q;
    cin_d   = cin_q;
    caddr_d = caddr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          idx_d   = '0;
          csum_d  = '0;
          state_d = ST_B0;
        end
      end
      ST_B0: begin
        if (xfer) begin
          // Only bit 0 of the leading byte carries coefficient data.
          if (byte_in[7:1] != 7'd0) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            b0_d    = byte_in[0];
            csum_d  = csum_q + byte_in;
            state_d = ST_B1;
          end
        end
      end
      ST_B1: begin
        if (xfer) begin
          b1_d    = byte_in;
          csum_d  = csum_q + byte_in;
          state_d = ST_B2;
        end
      end
      ST_B2: begin
        if (xfer) begin
          cin_d   = {b0_q, b1_q, byte_in};
          caddr_d = idx_q;
          csum_d  = csum_q + byte_in;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (idx_q == AW'(NTAPS - 1)) begin
          state_d = ST_CHK;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_B0;
        end
      end
      ST_CHK: begin
        if (xfer) begin
          if (byte_in == csum_q) begin
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      b0_q    <= 1'b0;
      b1_q    <= '0;
      err_q   <= 1'b0;
      cin_q   <= '0;
      caddr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      err_q   <= err_d;
      cin_q   <= cin_d;
      caddr_q <= caddr_d;
    end
  end

endmodule

// File: tb/tb_w4823_cmem_loader.sv
// Scoreboard bench for w4823_cmem_loader: expected CMEM writes and done
// pulses are queued by the stimulus and consumed by an independent monitor.
module tb_w4823_cmem_loader;
  import w4823_cmem_loader_pkg::*;

  logic          clk_fast = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [CW-1:0] cin;
  logic [AW-1:0] caddr;
  logic          cload;
  logic          busy;
  logic          done;
  logic          err;

  w4823_cmem_loader dut (
    .clk_fast   (clk_fast),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .cin        (cin),
    .caddr      (caddr),
    .cload      (cload),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk_fast = ~clk_fast;

  int cyc = 0;
  always @(posedge clk_fast) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  int            n_checks = 0;
  int            n_errors = 0;
  wr_t           wr_q[$];
  int            done_q[$];
  logic [CW-1:0] coefs[NTAPS];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flagFailure(input string name);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every strobe must match the next queued write, and cin/caddr
  // must still hold that value one cycle later.
  bit  prev_cload = 1'b0;
  wr_t prev_exp;
  always @(negedge clk_fast) begin
    if (prev_cload) begin
      checkOutput("cin_hold", 32'(cin), prev_exp.data);
      checkOutput("caddr_hold", 32'(caddr), prev_exp.addr);
    end
    prev_cload = 1'b0;
    if (cload === 1'b1) begin
      if (wr_q.size() == 0) begin
        flagFailure($sformatf("unexpected_cload caddr=%0d cin=%0h", caddr, cin));
      end else begin
        prev_exp = wr_q.pop_front();
        checkOutput("caddr", 32'(caddr), prev_exp.addr);
        checkOutput("cin", 32'(cin), prev_exp.data);
        prev_cload = 1'b1;
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        flagFailure("unexpected_done");
      end else begin
        int exp_cyc;
        exp_cyc = done_q.pop_front();
        if (exp_cyc >= 0) checkOutput("done_cycle", cyc, exp_cyc);
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_byte_ready"}, 32'(byte_ready), 0);
    checkOutput({tag, "_cin"}, 32'(cin), 0);
    checkOutput({tag, "_caddr"}, 32'(caddr), 0);
    checkOutput({tag, "_cload"}, 32'(cload), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit bp);
    int waited;
    if (bp) begin
      while ($urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        @(posedge clk_fast); #1;
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    waited     = 0;
    while (byte_ready !== 1'b1 && waited < 20) begin
      @(posedge clk_fast); #1;
      waited++;
    end
    if (byte_ready !== 1'b1) flagFailure("byte_ready_timeout");
    else begin
      @(posedge clk_fast); #1;
    end
  endtask

  // One load: bad_idx < NTAPS corrupts that coefficient's B0, csum_delta
  // offsets the checksum, start_mid re-pulses start during that coefficient,
  // reset_idx >= 0 resets the DUT during that coefficient.
  task automatic applyStimulus(input bit bp, input int bad_idx, input int csum_delta,
                               input int start_mid, input int reset_idx);
    logic [7:0] sum;
    logic [7:0] b;
    int         n_wr;
    int         waited;
    bit         good;
    sum  = 8'd0;
    n_wr = bad_idx;
    if (reset_idx >= 0 && reset_idx < n_wr) n_wr = reset_idx;
    for (int k = 0; k < n_wr; k++) wr_q.push_back('{addr: k, data: int'(coefs[k])});
    good = (bad_idx >= NTAPS) && (csum_delta == 0) && (reset_idx < 0);

    start = 1'b1;
    if (good) done_q.push_back(bp ? -1 : cyc + 258);
    @(posedge clk_fast); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 1);
    checkOutput("ready_after_start", 32'(byte_ready), 1);
    checkOutput("err_after_start", 32'(err), 0);

    for (int k = 0; k < NTAPS; k++) begin
      for (int j = 0; j < BYTES_PER_COEF; j++) begin
        if (j == 0) b = {7'd0, coefs[k][16]};
        else if (j == 1) b = coefs[k][15:8];
        else b = coefs[k][7:0];
        if (k == bad_idx && j == 0) b = 8'h02;
        if (k == reset_idx && j == 1) begin
          rst_n = 1'b0;
          #1;
          checkResetOutputs("mid_reset");
          wr_q.delete();
          done_q.delete();
          byte_valid = 1'b0;
          repeat (3) @(posedge clk_fast);
          #1;
          rst_n = 1'b1;
          return;
        end
        if (k == start_mid && j == 1) start = 1'b1;
        sendByte(b, bp);
        start = 1'b0;
        sum = sum + b;
        if (k == bad_idx && j == 0) begin
          checkOutput("fmt_err_busy", 32'(busy), 0);
          checkOutput("fmt_err_err", 32'(err), 1);
          byte_valid = 1'b0;
          repeat (6) @(posedge clk_fast);
          #1;
          checkOutput("fmt_err_writes_left", wr_q.size(), 0);
          checkOutput("fmt_err_err_sticky", 32'(err), 1);
          return;
        end
      end
    end

    sendByte(sum + 8'(csum_delta), bp);
    byte_valid = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 10) begin
      @(posedge clk_fast); #1;
      waited++;
    end
    checkOutput("busy_end", 32'(busy), 0);
    checkOutput("err_end", 32'(err), (csum_delta != 0) ? 1 : 0);
    checkOutput("writes_left", wr_q.size(), 0);
    checkOutput("done_left", done_q.size(), 0);
    checkOutput("caddr_final", 32'(caddr), NTAPS - 1);
  endtask

  task automatic planCoefs();
    for (int k = 0; k < NTAPS; k++) coefs[k] = {1'(k & 1), 8'(k), 8'(255 - k)};
  endtask

  task automatic randomCoefs();
    for (int k = 0; k < NTAPS; k++) coefs[k] = CW'($urandom);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    repeat (3) @(posedge clk_fast);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk_fast); #1;
    checkResetOutputs("idle");

    $display("[TB] full load");
    planCoefs();
    applyStimulus(1'b0, NTAPS, 0, -1, -1);

    $display("[TB] backpressure");
    applyStimulus(1'b1, NTAPS, 0, -1, -1);

    $display("[TB] format error");
    applyStimulus(1'b0, 5, 0, -1, -1);

    $display("[TB] checksum error after format error");
    applyStimulus(1'b1, NTAPS, 1, -1, -1);

    $display("[TB] reset mid-load then full load");
    applyStimulus(1'b0, NTAPS, 0, -1, 10);
    checkResetOutputs("after_reset");
    applyStimulus(1'b0, NTAPS, 0, -1, -1);

    $display("[TB] start during load");
    applyStimulus(1'b0, NTAPS, 0, 20, -1);

    $display("[TB] random coefficients");
    for (int r = 0; r < 3; r++) begin
      randomCoefs();
      applyStimulus(r != 0, NTAPS, 0, -1, -1);
    end
    randomCoefs();
    applyStimulus(1'b1, int'($urandom_range(0, NTAPS - 1)), 0, -1, -1);
    randomCoefs();
    applyStimulus(1'b0, NTAPS, int'($urandom_range(1, 255)), -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
